// File: rtl/fp_divsqrt_dispatcher.sv
// Multi-core front end for the shared iterative FP div/sqrt unit.
// Define FP_DIVSQRT_RR_ARB_EN for round-robin; default is fixed priority.
module fp_divsqrt_dispatcher #(
    parameter int NUM_CORES  = 4,
    parameter int FP_WIDTH   = 32,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 5,
    parameter int TAG_WIDTH  = $clog2(NUM_CORES)
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_CORES-1:0]                req_valid_i,
    output logic [NUM_CORES-1:0]                req_ready_o,
    input  logic [NUM_CORES-1:0][FP_WIDTH-1:0]  req_opa_i,
    input  logic [NUM_CORES-1:0][FP_WIDTH-1:0]  req_opb_i,
    input  logic [NUM_CORES-1:0]                req_sqrt_i,
    input  logic [NUM_CORES-1:0][RND_WIDTH-1:0] req_rnd_i,
    output logic [NUM_CORES-1:0]                resp_valid_o,
    input  logic [NUM_CORES-1:0]                resp_ready_i,
    output logic [FP_WIDTH-1:0]                 resp_res_o,
    output logic [STAT_WIDTH-1:0]               resp_status_o,
    output logic                                du_en_o,
    output logic [FP_WIDTH-1:0]                 du_opa_o,
    output logic [FP_WIDTH-1:0]                 du_opb_o,
    output logic                                du_sqrt_sel_o,
    output logic [RND_WIDTH-1:0]                du_rnd_o,
    output logic [TAG_WIDTH-1:0]                du_tag_o,
    input  logic                                du_ready_i,
    input  logic                                du_valid_i,
    input  logic [FP_WIDTH-1:0]                 du_res_i,
    input  logic [STAT_WIDTH-1:0]               du_status_i,
    input  logic [TAG_WIDTH-1:0]                du_tag_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [FP_WIDTH-1:0]   res_q;
    logic [STAT_WIDTH-1:0] status_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  grant_any;
    logic [TAG_WIDTH-1:0]  win;
    logic                  issue;
    logic                  resp_hs;

`ifdef FP_DIVSQRT_RR_ARB_EN
    logic [TAG_WIDTH-1:0] ptr_q;
    int                   idx;

    // Search starts at the pointer; ptr_q < NUM_CORES, so one wrap suffices.
    always_comb begin
        grant_any = 1'b0;
        win       = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_CORES) idx = idx - NUM_CORES;
            if (!grant_any && req_valid_i[idx]) begin
                grant_any = 1'b1;
                win       = TAG_WIDTH'(idx);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (resp_hs) begin
            if (tag_q == TAG_WIDTH'(NUM_CORES - 1)) ptr_q <= '0;
            else ptr_q <= tag_q + 1'b1;
        end
    end
`else
    always_comb begin
        grant_any = 1'b0;
        win       = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                grant_any = 1'b1;
                win       = TAG_WIDTH'(k);
            end
        end
    end
`endif

    // Reset gates the grant so nothing is offered while rst_ni is low.
    assign issue = rst_ni && (state_q == IDLE) && du_ready_i && grant_any;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY:    if (du_valid_i) state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o   = '0;
        du_en_o       = 1'b0;
        du_opa_o      = '0;
        du_opb_o      = '0;
        du_sqrt_sel_o = 1'b0;
        du_rnd_o      = '0;
        du_tag_o      = '0;
        if (issue) begin
            req_ready_o[win] = 1'b1;
            du_en_o          = 1'b1;
            du_opa_o         = req_opa_i[win];
            du_opb_o         = req_opb_i[win];
            du_sqrt_sel_o    = req_sqrt_i[win];
            du_rnd_o         = req_rnd_i[win];
            du_tag_o         = win;
        end
    end

    // Routing follows the tag the unit hands back, not the issued winner.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            res_q    <= '0;
            status_q <= '0;
            tag_q    <= '0;
        end else if (state_q == BUSY && du_valid_i) begin
            res_q    <= du_res_i;
            status_q <= du_status_i;
            tag_q    <= du_tag_i;
        end
    end

    always_comb begin
        resp_valid_o = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            resp_valid_o[i] = (state_q == RESP) && (tag_q == TAG_WIDTH'(i));
        end
    end

    assign resp_hs       = |(resp_valid_o & resp_ready_i);
    assign resp_res_o    = (state_q == RESP) ? res_q : '0;
    assign resp_status_o = (state_q == RESP) ? status_q : '0;

endmodule

// File: tb/tb_fp_divsqrt_dispatcher.sv
// Bench for fp_divsqrt_dispatcher: directed scenarios plus random traffic
// against a transaction-level model of arbitration and response routing.
module tb_fp_divsqrt_dispatcher;

    localparam int NC = 4;
    localparam int FW = 32;
    localparam int RW = 3;
    localparam int SW = 5;
    localparam int TW = 2;

    logic                   clk;
    logic                   rst_ni;
    logic [NC-1:0]          req_valid_i;
    logic [NC-1:0]          req_ready_o;
    logic [NC-1:0][FW-1:0]  req_opa_i;
    logic [NC-1:0][FW-1:0]  req_opb_i;
    logic [NC-1:0]          req_sqrt_i;
    logic [NC-1:0][RW-1:0]  req_rnd_i;
    logic [NC-1:0]          resp_valid_o;
    logic [NC-1:0]          resp_ready_i;
    logic [FW-1:0]          resp_res_o;
    logic [SW-1:0]          resp_status_o;
    logic                   du_en_o;
    logic [FW-1:0]          du_opa_o;
    logic [FW-1:0]          du_opb_o;
    logic                   du_sqrt_sel_o;
    logic [RW-1:0]          du_rnd_o;
    logic [TW-1:0]          du_tag_o;
    logic                   du_ready_i;
    logic                   du_valid_i;
    logic [FW-1:0]          du_res_i;
    logic [SW-1:0]          du_status_i;
    logic [TW-1:0]          du_tag_i;

    fp_divsqrt_dispatcher dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_opa_i    (req_opa_i),
        .req_opb_i    (req_opb_i),
        .req_sqrt_i   (req_sqrt_i),
        .req_rnd_i    (req_rnd_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_res_o   (resp_res_o),
        .resp_status_o(resp_status_o),
        .du_en_o      (du_en_o),
        .du_opa_o     (du_opa_o),
        .du_opb_o     (du_opb_o),
        .du_sqrt_sel_o(du_sqrt_sel_o),
        .du_rnd_o     (du_rnd_o),
        .du_tag_o     (du_tag_o),
        .du_ready_i   (du_ready_i),
        .du_valid_i   (du_valid_i),
        .du_res_i     (du_res_i),
        .du_status_i  (du_status_i),
        .du_tag_i     (du_tag_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction model: one op in flight, one response waiting, last served.
    bit      m_out;
    bit      m_resp;
    int      m_tag;
    logic [FW-1:0] m_res;
    logic [SW-1:0] m_stat;
    int      m_ptr;

    // Core and unit behaviour for random traffic.
    logic [NC-1:0] hold;
    bit      u_busy;
    int      u_lat;
    int      u_tag;
    int      lat_max = 4;
    bit      noise = 1'b0;
    int      obs_grants[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NC-1:0] v, input int ptr);
        int c;
        for (int k = 0; k < NC; k++) begin
`ifdef FP_DIVSQRT_RR_ARB_EN
            c = (ptr + k) % NC;
`else
            c = k + (ptr - ptr);
`endif
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Check every output against the model, then advance one clock.
    task automatic cyc();
        int w;
        logic [NC-1:0] e_rdy;
        logic [NC-1:0] e_rv;
        #1;
        w     = -1;
        e_rdy = '0;
        e_rv  = '0;
        if (rst_ni && !m_out && !m_resp && du_ready_i)
            w = pick(req_valid_i, m_ptr);
        if (w >= 0) e_rdy[w] = 1'b1;
        if (rst_ni && m_resp) e_rv[m_tag] = 1'b1;
        check("req_ready", 64'(req_ready_o), 64'(e_rdy));
        check("du_en", 64'(du_en_o), 64'(w >= 0));
        check("du_opa", 64'(du_opa_o), (w >= 0) ? 64'(req_opa_i[w]) : 64'd0);
        check("du_opb", 64'(du_opb_o), (w >= 0) ? 64'(req_opb_i[w]) : 64'd0);
        check("du_sqrt", 64'(du_sqrt_sel_o),
              (w >= 0) ? 64'(req_sqrt_i[w]) : 64'd0);
        check("du_rnd", 64'(du_rnd_o), (w >= 0) ? 64'(req_rnd_i[w]) : 64'd0);
        check("du_tag", 64'(du_tag_o), (w >= 0) ? 64'(w) : 64'd0);
        check("resp_valid", 64'(resp_valid_o), 64'(e_rv));
        check("resp_res", 64'(resp_res_o),
              (rst_ni && m_resp) ? 64'(m_res) : 64'd0);
        check("resp_status", 64'(resp_status_o),
              (rst_ni && m_resp) ? 64'(m_stat) : 64'd0);
        if (du_en_o) obs_grants.push_back(int'(du_tag_o));
        if (!rst_ni) begin
            m_out  = 1'b0;
            m_resp = 1'b0;
            m_tag  = 0;
            m_res  = '0;
            m_stat = '0;
            m_ptr  = 0;
        end else if (w >= 0) begin
            m_out   = 1'b1;
            hold[w] = 1'b0;
            u_busy  = 1'b1;
            u_lat   = $urandom_range(lat_max, 1);
            u_tag   = (noise && ($urandom % 8 == 0)) ? int'($urandom % NC) : w;
        end else if (m_out && du_valid_i) begin
            m_out  = 1'b0;
            m_resp = 1'b1;
            m_tag  = int'(du_tag_i);
            m_res  = du_res_i;
            m_stat = du_status_i;
        end else if (m_resp && resp_ready_i[m_tag]) begin
            m_resp = 1'b0;
            m_ptr  = (m_tag + 1) % NC;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        req_valid_i  = '0;
        req_opa_i    = '0;
        req_opb_i    = '0;
        req_sqrt_i   = '0;
        req_rnd_i    = '0;
        resp_ready_i = '0;
        du_ready_i   = 1'b0;
        du_valid_i   = 1'b0;
        du_res_i     = '0;
        du_status_i  = '0;
        du_tag_i     = '0;
    endtask

    task automatic drive(input logic [NC-1:0] mask, input int req_pct,
                         input int resp_pct, input int rdy_pct);
        for (int i = 0; i < NC; i++) begin
            if (!hold[i] && mask[i] && ($urandom % 100 < req_pct)) begin
                hold[i]       = 1'b1;
                req_opa_i[i]  = $urandom;
                req_opb_i[i]  = $urandom;
                req_sqrt_i[i] = 1'($urandom);
                req_rnd_i[i]  = RW'($urandom);
            end
            resp_ready_i[i] = ($urandom % 100 < resp_pct);
        end
        req_valid_i = hold;
        du_valid_i  = 1'b0;
        du_tag_i    = '0;
        du_res_i    = '0;
        du_status_i = '0;
        if (u_busy) begin
            u_lat--;
            if (u_lat <= 0) begin
                du_valid_i  = 1'b1;
                du_tag_i    = TW'(u_tag);
                du_res_i    = $urandom;
                du_status_i = SW'($urandom);
                u_busy      = 1'b0;
            end
        end else if (noise && ($urandom % 10 == 0)) begin
            du_valid_i  = 1'b1;
            du_tag_i    = TW'($urandom);
            du_res_i    = $urandom;
            du_status_i = SW'($urandom);
        end
        du_ready_i = !u_busy && ($urandom % 100 < rdy_pct);
    endtask

    task automatic pulse_reset();
        zero_inputs();
        rst_ni = 1'b0;
        cyc();
        rst_ni = 1'b1;
        hold   = '0;
        u_busy = 1'b0;
        cyc();
    endtask

    initial begin
        int exp_bu;
        int exp_rr[4];
        zero_inputs();
        hold   = '0;
        u_busy = 1'b0;
        rst_ni = 1'b0;
        m_ptr  = 0;
        @(posedge clk);
        #1;
        req_valid_i = '1;
        du_ready_i  = 1'b1;
        #1;
        check("rst_grant", 64'(req_ready_o), 64'd0);
        check("rst_en", 64'(du_en_o), 64'd0);
        check("rst_resp", 64'(resp_valid_o), 64'd0);
        cyc();
        zero_inputs();
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Single divide on core 2
        req_valid_i  = 4'b0100;
        req_opa_i[2] = 32'h4040_0000;
        req_opb_i[2] = 32'h3F80_0000;
        du_ready_i   = 1'b1;
        #1;
        check("sd_grant", 64'(req_ready_o), 64'h4);
        check("sd_en", 64'(du_en_o), 64'd1);
        check("sd_tag", 64'(du_tag_o), 64'd2);
        cyc();
        req_valid_i = '0;
        du_ready_i  = 1'b0;
        cyc();
        du_valid_i = 1'b1;
        du_tag_i   = 2'd2;
        du_res_i   = 32'h4040_0000;
        cyc();
        du_valid_i = 1'b0;
        du_res_i   = '0;
        req_valid_i = '1;
        du_ready_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_valid", 64'(resp_valid_o), 64'h4);
            check("bp_res", 64'(resp_res_o), 64'h4040_0000);
            check("bp_en", 64'(du_en_o), 64'd0);
            cyc();
        end
        req_valid_i  = '0;
        resp_ready_i = 4'b0100;
        cyc();
        resp_ready_i = '0;

        // Spurious unit valid while idle
        du_valid_i = 1'b1;
        du_tag_i   = 2'd1;
        du_res_i   = 32'hDEAD_BEEF;
        cyc();
        du_valid_i = 1'b0;
        #1;
        check("spur_resp", 64'(resp_valid_o), 64'd0);
        cyc();

        // Unit not ready with every core asking
        req_valid_i = '1;
        du_ready_i  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bu_hold", 64'(du_en_o), 64'd0);
            cyc();
        end
        du_ready_i = 1'b1;
`ifdef FP_DIVSQRT_RR_ARB_EN
        exp_bu = 3;
`else
        exp_bu = 0;
`endif
        #1;
        check("bu_en", 64'(du_en_o), 64'd1);
        check("bu_tag", 64'(du_tag_o), 64'(exp_bu));
        cyc();
        req_valid_i = '0;
        du_ready_i  = 1'b0;
        cyc();
        du_valid_i = 1'b1;
        du_tag_i   = TW'(exp_bu);
        du_res_i   = 32'h3F80_0000;
        cyc();
        du_valid_i   = 1'b0;
        resp_ready_i = '1;
        cyc();
        resp_ready_i = '0;
        cyc();

        // Random traffic
        hold   = '0;
        u_busy = 1'b0;
        noise  = 1'b1;
        lat_max = 5;
        for (int i = 0; i < 3000; i++) begin
            drive(4'b1111, 30, 60, 80);
            cyc();
        end
        noise   = 1'b0;
        lat_max = 1;
        pulse_reset();

        // Cores 0 and 3 asking back to back
        obs_grants.delete();
        for (int i = 0; i < 80 && obs_grants.size() < 4; i++) begin
            drive(4'b1001, 100, 100, 100);
            cyc();
        end
`ifdef FP_DIVSQRT_RR_ARB_EN
        exp_rr = '{0, 3, 0, 3};
`else
        exp_rr = '{0, 0, 0, 0};
`endif
        check("rr_count", 64'(obs_grants.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_grant%0d", i),
                  (obs_grants.size() > i) ? 64'(obs_grants[i]) : 64'hFFFF,
                  64'(exp_rr[i]));
        end
        pulse_reset();

        // Serve core 2, then reset while core 1 is in flight
        req_valid_i = 4'b0100;
        du_ready_i  = 1'b1;
        cyc();
        req_valid_i = '0;
        du_ready_i  = 1'b0;
        cyc();
        du_valid_i = 1'b1;
        du_tag_i   = 2'd2;
        du_res_i   = 32'h1234_5678;
        cyc();
        du_valid_i   = 1'b0;
        resp_ready_i = 4'b0100;
        cyc();
        resp_ready_i = '0;
        req_valid_i  = 4'b0010;
        du_ready_i   = 1'b1;
        cyc();
        req_valid_i = '0;
        du_ready_i  = 1'b0;
        cyc();
        rst_ni      = 1'b0;
        req_valid_i = '1;
        du_ready_i  = 1'b1;
        #1;
        check("mid_rst_en", 64'(du_en_o), 64'd0);
        check("mid_rst_grant", 64'(req_ready_o), 64'd0);
        check("mid_rst_resp", 64'(resp_valid_o), 64'd0);
        cyc();
        rst_ni      = 1'b1;
        req_valid_i = '0;
        du_ready_i  = 1'b0;
        du_valid_i  = 1'b1;
        du_tag_i    = 2'd1;
        du_res_i    = 32'hCAFE_F00D;
        cyc();
        du_valid_i = 1'b0;
        #1;
        check("late_drop", 64'(resp_valid_o), 64'd0);
        cyc();
        req_valid_i = 4'b1010;
        du_ready_i  = 1'b1;
        #1;
        check("post_rst_grant", 64'(req_ready_o), 64'h2);
        cyc();
        zero_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
